control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  single system clock; all state changes on rising edge.
REQ-002 clear  input  1  reset, asynchronous, active-high.
REQ-003 stop  input  1  request to idle; sampled only on the instruction boundary.
REQ-004 mem_ready  input  1  memory read data valid on mDataIn this cycle.
REQ-005 ir  input  32  current IR contents: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-006 PCout, IncPC, MARin  output  1 each  fetch-address controls.
REQ-007 memRead, MDRin  output  1 each  memory read and MDR load.
REQ-008 MDRout, IRin  output  1 each  MDR-to-bus and IR load.
REQ-009 Yin, Zin  output  1 each  ALU operand and result latch enables.
REQ-010 Zhighout, Zlowout  output  1 each  Z halves to bus.
REQ-011 HIin, LOin  output  1 each  HI/LO load enables.
REQ-012 Rout  output  16  one-hot general-register bus drive.
REQ-013 Rin  output  16  one-hot general-register load.
REQ-014 alu_op  output  5  operation code presented to the ALU.
REQ-015 run  output  1  high while sequencing instructions.
REQ-016 illegal  output  1  sticky flag: an undefined opcode was decoded.

Function
REQ-017 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED; outputs decode from state and ir only.
REQ-018 Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000, NOP 11010, HALT 11011; all others are illegal.
REQ-019 IDLE: all controls 0, run=0; next edge goes to T0 if stop=0, else stays.
REQ-020 T0: PCout=IncPC=MARin=1; next T1.
REQ-021 T1: memRead=MDRin=1; stays in T1 with outputs held while mem_ready=0; goes to T2 on an edge with mem_ready=1.
REQ-022 T2: MDRout=IRin=1; next T3 (ir is valid from T3 onward).
REQ-023 T3, ALU/MUL/DIV opcodes: Rout=1<<rb, Yin=1; next T4.
REQ-024 T3, NOP: no controls asserted; next is the instruction boundary.
REQ-025 T3, HALT: no controls asserted; next HALTED.
REQ-026 T3, illegal opcode: no controls asserted; illegal set at the T3->boundary edge; next is the boundary.
REQ-027 T4: Rout=1<<rc, Zin=1, alu_op=opcode; alu_op SHALL be 00000 in every other state.
REQ-028 T5, ADD/SUB/AND/OR: Zlowout=1, Rin=1<<ra; next is the boundary.
REQ-029 T5, MUL/DIV: Zlowout=1, LOin=1, Rin=0; next T6.
REQ-030 T6: Zhighout=1, HIin=1; next is the boundary.
REQ-031 Boundary: go to T0 if stop=0, else to IDLE.
REQ-032 HALTED: all controls 0, run=0; only clear exits, and stop is ignored.
REQ-033 run SHALL be 1 in T0-T6 and 0 in IDLE and HALTED.
REQ-034 At most one bit of Rout and one bit of Rin SHALL be set in any cycle; ra=0 is legal and yields Rin=0x0001.

Reset
REQ-035 clear=1 SHALL immediately force state IDLE, all outputs 0, run=0, illegal=0, in any state including mid-instruction and during a T1 wait.
REQ-036 After clear deasserts, the first rising edge with stop=0 SHALL enter T0.

Verification
REQ-037 SUB: ir=0x2091_8000, mem_ready=1 -> T0..T5 in 6 cycles; T3 Rout=0x0004 with Yin; T4 Rout=0x0008 with Zin and alu_op=00100; T5 Rin=0x0002 with Zlowout; then T0.
REQ-038 Memory wait: mem_ready low for 3 cycles in T1 -> memRead=MDRin=1 for 4 cycles, then T2.
REQ-039 MUL: ir=0x7891_8000 -> T5 LOin with Zlowout, T6 HIin with Zhighout, Rin=0 throughout, then T0.
REQ-040 Illegal/stop: ir=0xF800_0000 with stop=1 at the boundary -> illegal=1 stays set; the block enters IDLE with run=0.
REQ-041 HALT: ir=0xD800_0000 -> HALTED after T3; run=0 and stays 0 while stop toggles.
REQ-042 Reset mid-T4 -> outputs 0 in the same cycle without a clock edge; the first edge after release enters T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle datapath control sequencer: fetch (T0-T2) then execute (T3-T6) per opcode.
// Moore outputs decode from the state register and the instruction register.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        stop,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        memRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalted
    } state_e;

    state_e state_q, state_d, boundary;
    logic   illegal_q;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_nop, is_halt, is_illegal;
    logic       unused_ir_low;

    assign opcode        = ir[31:27];
    assign ra            = ir[26:23];
    assign rb            = ir[22:19];
    assign rc            = ir[18:15];
    assign unused_ir_low = ^ir[14:0];

    assign is_alu     = (opcode == OpAdd) || (opcode == OpSub) ||
                        (opcode == OpAnd) || (opcode == OpOr);
    assign is_muldiv  = (opcode == OpMul) || (opcode == OpDiv);
    assign is_nop     = (opcode == OpNop);
    assign is_halt    = (opcode == OpHalt);
    assign is_illegal = !(is_alu || is_muldiv || is_nop || is_halt);

    function automatic logic [15:0] reg_sel(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // Instruction boundary: stop is honoured only here.
    assign boundary = stop ? StIdle : StT0;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            illegal_q <= 1'b0;
        end else if (state_q == StT3 && is_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!stop) state_d = StT0;
            StT0:     state_d = StT1;
            StT1:     if (mem_ready) state_d = StT2;
            StT2:     state_d = StT3;
            StT3: begin
                if (is_alu || is_muldiv) begin
                    state_d = StT4;
                end else if (is_halt) begin
                    state_d = StHalted;
                end else begin
                    state_d = boundary;
                end
            end
            StT4:     state_d = StT5;
            StT5:     state_d = is_muldiv ? StT6 : boundary;
            StT6:     state_d = boundary;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        memRead  = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        alu_op   = 5'b00000;
        unique case (state_q)
            StT0: begin
                PCout = 1'b1;
                IncPC = 1'b1;
                MARin = 1'b1;
            end
            StT1: begin
                memRead = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                if (is_alu || is_muldiv) begin
                    Rout = reg_sel(rb);
                    Yin  = 1'b1;
                end
            end
            StT4: begin
                Rout   = reg_sel(rc);
                Zin    = 1'b1;
                alu_op = opcode;
            end
            StT5: begin
                Zlowout = 1'b1;
                // MUL/DIV results land in LO/HI, never in a general register.
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin = reg_sel(ra);
                end
            end
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign run     = (state_q != StIdle) && (state_q != StHalted);
    assign illegal = illegal_q;

    a_rout_onehot: assert property (@(posedge clock) disable iff (clear) $onehot0(Rout));
    a_rin_onehot:  assert property (@(posedge clock) disable iff (clear) $onehot0(Rin));
    a_alu_op_idle: assert property (@(posedge clock) disable iff (clear)
                                    (state_q != StT4) |-> (alu_op == 5'b00000));

endmodule
